stall_flush_ctrl: RTL and testbench
===================================

# stall_flush_ctrl

Pipeline stall/flush controller for the 5-stage ARM core. It consumes the `hazard_Detected` flag from the hazard unit, the taken-branch signal from EXE and the SRAM ready handshake from MEM. It turns them into the freeze, flush and bubble controls that drive PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB. It also tracks consecutive stall cycles for watchdog errors and keeps saturating performance counters.

## Interface
- `CNT_W`, 16, width of each performance counter
- `MAX_STALL`, 4, consecutive hazard-stall cycles that trigger the watchdog
- `MEM_TIMEOUT`, 64, consecutive SRAM-wait cycles that trigger the watchdog

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `hazard_detected` in 1: RAW hazard flag from the hazard unit, ID stage.
- `branch_taken` in 1: branch resolved taken, EXE stage.
- `mem_req` in 1: MEM-stage instruction has MEM_R_EN or MEM_W_EN set.
- `sram_ready` in 1: SRAM controller access complete.
- `cnt_clr` in 1: synchronous clear of the performance counters.
- `freeze_pc` out 1: hold PC.
- `freeze_if_id` out 1: hold the IF/ID register.
- `flush_if_id` out 1: zero IF/ID on the next edge.
- `flush_id_exe` out 1: load a bubble into ID/EXE.
- `freeze_all` out 1: hold PC and all four pipeline registers.
- `error` out 1: sticky watchdog flag.
- `stall_cnt` out CNT_W: hazard-stall cycles.
- `flush_cnt` out CNT_W: branch-flush cycles.
- `mem_wait_cnt` out CNT_W: SRAM-wait cycles.

## Operation
- Define `mem_wait` = `mem_req & ~sram_ready`.
- States: RUN, HAZ_STALL, MEM_WAIT, ERROR. Reset state is RUN.
- Control outputs are combinational (Mealy) from the state and the current inputs. Priority, highest first:
  1. ERROR: `freeze_all`=1, `freeze_pc`=1, `freeze_if_id`=1, all flushes 0, `error`=1.
  2. `mem_wait`: `freeze_all`=1, `freeze_pc`=1, `freeze_if_id`=1, flushes 0. A simultaneous branch is not applied; it is re-presented because EXE is held.
  3. `branch_taken`: `flush_if_id`=1, `flush_id_exe`=1, no freezes. The hazard is ignored because ID holds a wrong-path instruction.
  4. `hazard_detected`: `freeze_pc`=1, `freeze_if_id`=1, `flush_id_exe`=1.
  5. Otherwise all controls are 0.
- Transitions are evaluated at the rising edge using the condition active that cycle, under the same priority:
  - Any non-ERROR state goes to MEM_WAIT if `mem_wait` is active.
  - Otherwise it goes to HAZ_STALL if case 4 applies.
  - Otherwise it goes to RUN.
  - ERROR is left only by reset.
- Internal consecutive counter `run_len`:
  - It counts cycles spent in the same stall condition (case 2 or case 4).
  - It is cleared on any other cycle or when the condition changes.
  - When case 4 is active and `run_len == MAX_STALL-1`, the next state is ERROR.
  - When case 2 is active and `run_len == MEM_TIMEOUT-1`, the next state is ERROR.
- Performance counters:
  - `stall_cnt` increments on case-4 cycles.
  - `flush_cnt` increments on case-3 cycles.
  - `mem_wait_cnt` increments on cycles where case 2 applies or the state is ERROR.
  - Each counter saturates at 2^CNT_W-1.
  - `cnt_clr` wins over a simultaneous increment, giving 0 after the edge.
- `error` = (state == ERROR). It stays set until `rst` is asserted.

## Timing
- While `rst`=0: state=RUN, `run_len`=0, all counters 0, `error`=0. All control outputs are forced to 0 regardless of inputs.
- Release of `rst` is asynchronous-assert, synchronous-deassert. The block is assumed to be reset-synchronized upstream.
- Control outputs have zero latency: same cycle as the causing input.
- Counters and state update on the edge that ends the causing cycle.
- `mem_req` with `sram_ready`=1 in the same cycle causes no freeze.
- Freeze drops in the same cycle `sram_ready` rises.
- A hazard stall of MAX_STALL cycles is legal. ERROR (and `error`=1) first appears in cycle MAX_STALL+1 of a continuous `hazard_detected`.
- An asynchronous reset mid-stall returns to RUN immediately. Controls go to 0 without waiting for a clock.

## Test plan
- Hazard for 2 cycles, then clear: `freeze_pc`/`freeze_if_id`/`flush_id_exe`=1 for exactly those 2 cycles. `stall_cnt`=2 afterwards, `error`=0.
- `hazard_detected`=1 and `branch_taken`=1 together: `flush_if_id`=`flush_id_exe`=1, `freeze_pc`=0. `flush_cnt`=1, `stall_cnt`=0.
- `mem_req`=1 with `sram_ready` low for 5 cycles while `branch_taken`=1: `freeze_all`=1 for 5 cycles with no flush. On the 6th cycle (`sram_ready`=1) flushes assert. `mem_wait_cnt`=5, `flush_cnt`=1.
- `hazard_detected` held for 5 cycles with MAX_STALL=4: `error` rises in cycle 5 with `freeze_all`=1. It stays set after the hazard clears, until `rst`=0.
- CNT_W=4 with 20 hazard cycles spread to avoid the watchdog: `stall_cnt` saturates at 15. `cnt_clr` together with a hazard cycle gives `stall_cnt`=0.
- `rst` asserted low mid-MEM_WAIT between clock edges: all controls go to 0 immediately, and counters and `error` read 0.

Source files
------------

// File: rtl/stall_flush_ctrl.sv
// -----------------------------------------------------------------------------
// stall_flush_ctrl
//
// Pipeline stall/flush controller for the 5-stage ARM core. It merges the ID
// hazard flag, the EXE taken-branch signal and the MEM-stage SRAM handshake
// into the freeze, flush and bubble controls for PC, IF/ID, ID/EXE, EXE/MEM
// and MEM/WB. It also runs a watchdog on consecutive stall cycles and keeps
// three saturating performance counters.
//
// Parameters:
//   CNT_W        width of each performance counter
//   MAX_STALL    consecutive hazard-stall cycles that trip the watchdog
//   MEM_TIMEOUT  consecutive SRAM-wait cycles that trip the watchdog
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   hazard_detected RAW hazard flag (ID stage)
//   branch_taken    branch resolved taken (EXE stage)
//   mem_req         MEM-stage instruction reads or writes memory
//   sram_ready      SRAM access complete
//   cnt_clr         synchronous clear of the performance counters
//   freeze_pc       hold PC
//   freeze_if_id    hold IF/ID
//   flush_if_id     zero IF/ID on the next edge
//   flush_id_exe    load a bubble into ID/EXE
//   freeze_all      hold PC and all four pipeline registers
//   error           sticky watchdog flag, cleared only by reset
//   stall_cnt       hazard-stall cycles (saturating)
//   flush_cnt       branch-flush cycles (saturating)
//   mem_wait_cnt    SRAM-wait cycles, including cycles spent in ERROR
// -----------------------------------------------------------------------------
module stall_flush_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MAX_STALL   = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_all,
  output logic             error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MEM_WAIT  = 2'd2,
    ERROR     = 2'd3
  } state_t;

  // run_len must be able to reach the larger of the two watchdog limits.
  localparam int RUN_MAX = (MAX_STALL > MEM_TIMEOUT) ? MAX_STALL : MEM_TIMEOUT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [RUN_W-1:0] HAZ_LIMIT = RUN_W'(MAX_STALL - 1);
  localparam logic [RUN_W-1:0] MEM_LIMIT = RUN_W'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_len_reg, run_len_next;
  logic [RUN_W-1:0] run_len_cur;

  logic mem_wait;
  logic in_error;
  logic case_mem;   // SRAM wait stall
  logic case_br;    // taken-branch flush
  logic case_haz;   // hazard stall
  logic same_cond;

  // ---------------------------------------------------------------------------
  // Priority decode. Each case excludes all higher-priority ones, so at most
  // one of case_mem / case_br / case_haz is set in any cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wait = mem_req & ~sram_ready;
    in_error = (state_reg == ERROR);
    case_mem = ~in_error & mem_wait;
    case_br  = ~in_error & ~mem_wait & branch_taken;
    case_haz = ~in_error & ~mem_wait & ~branch_taken & hazard_detected;
  end

  // ---------------------------------------------------------------------------
  // Consecutive-stall tracking. The state register already records which
  // stall condition (if any) held last cycle, so a run continues only when the
  // current condition matches it; otherwise this cycle counts as the first of
  // a new run.
  // ---------------------------------------------------------------------------
  always_comb begin
    same_cond   = (case_haz && (state_reg == HAZ_STALL)) ||
                  (case_mem && (state_reg == MEM_WAIT));
    run_len_cur = same_cond ? run_len_reg : '0;
  end

  // ---------------------------------------------------------------------------
  // Next state and next run length.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = RUN;
    run_len_next = '0;

    if (in_error) begin
      state_next = ERROR;
    end else if (case_mem) begin
      state_next   = (run_len_cur == MEM_LIMIT) ? ERROR : MEM_WAIT;
      run_len_next = run_len_cur + RUN_W'(1);
    end else if (case_haz) begin
      state_next   = (run_len_cur == HAZ_LIMIT) ? ERROR : HAZ_STALL;
      run_len_next = run_len_cur + RUN_W'(1);
    end

    // Nothing counts once the watchdog has fired.
    if (state_next == ERROR) begin
      run_len_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      run_len_reg <= '0;
    end else begin
      state_reg   <= state_next;
      run_len_reg <= run_len_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Mealy control outputs. Gated by rst so an asynchronous reset drops every
  // control immediately, without waiting for the state register to settle.
  // ---------------------------------------------------------------------------
  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    freeze_all   = 1'b0;
    error        = 1'b0;

    if (rst) begin
      if (in_error) begin
        freeze_all   = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        error        = 1'b1;
      end else if (case_mem) begin
        // A branch arriving now is dropped on purpose: EXE is frozen, so the
        // same branch is presented again once the SRAM completes.
        freeze_all   = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
      end else if (case_br) begin
        // ID holds a wrong-path instruction, so any hazard it raises is moot.
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (case_haz) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_exe = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters: 0 = stall, 1 = flush, 2 = SRAM wait.
  // A clear takes precedence over an increment in the same cycle.
  // ---------------------------------------------------------------------------
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  always_comb begin
    cnt_inc[0] = case_haz;
    cnt_inc[1] = case_br;
    cnt_inc[2] = case_mem | in_error;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_clr) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt    = cnt_reg[0];
  assign flush_cnt    = cnt_reg[1];
  assign mem_wait_cnt = cnt_reg[2];

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_flush_ctrl
//
// Directed-vector bench for stall_flush_ctrl (CNT_W=4, MAX_STALL=4,
// MEM_TIMEOUT=64). The driver applies one vector per cycle just after the
// rising edge and pushes the hand-computed response into a queue; a separate
// monitor pops one entry at every falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_stall_flush_ctrl;

  localparam int CW = 4;

  // Control bundle order: {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_all}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_HAZ  = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_MEM  = 5'b11001;
  localparam logic [4:0] C_ERR  = 5'b11001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hazard_detected = 1'b0;
  logic          branch_taken = 1'b0;
  logic          mem_req = 1'b0;
  logic          sram_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_all, error;
  logic [CW-1:0] stall_cnt, flush_cnt, mem_wait_cnt;

  stall_flush_ctrl #(
    .CNT_W      (CW),
    .MAX_STALL  (4),
    .MEM_TIMEOUT(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard_detected(hazard_detected),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .sram_ready     (sram_ready),
    .cnt_clr        (cnt_clr),
    .freeze_pc      (freeze_pc),
    .freeze_if_id   (freeze_if_id),
    .flush_if_id    (flush_if_id),
    .flush_id_exe   (flush_id_exe),
    .freeze_all     (freeze_all),
    .error          (error),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .mem_wait_cnt   (mem_wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] ctl;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
    logic [3:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic void push(input string nm, input logic [4:0] ctl, input bit er,
                               input int sc, input int fc, input int mc);
    exp_t e;
    e.name = nm;
    e.ctl  = ctl;
    e.err  = er;
    e.sc   = 4'(sc);
    e.fc   = 4'(fc);
    e.mc   = 4'(mc);
    exp_q.push_back(e);
  endfunction

  // One vector: inputs for a full cycle plus the expected response sampled
  // mid-cycle (controls are same-cycle, counters reflect earlier edges).
  task automatic vec(input string nm, input bit r, input bit h, input bit b,
                     input bit mr, input bit rdy, input bit clr,
                     input logic [4:0] ctl, input bit er,
                     input int sc, input int fc, input int mc);
    @(posedge clk);
    #1;
    rst             = r;
    hazard_detected = h;
    branch_taken    = b;
    mem_req         = mr;
    sram_ready      = rdy;
    cnt_clr         = clr;
    push(nm, ctl, er, sc, fc, mc);
  endtask

  // Asynchronous reset asserted between edges while the SRAM wait persists.
  task automatic rst_mid(input string nm);
    @(posedge clk);
    #1;
    hazard_detected = 1'b0;
    branch_taken    = 1'b0;
    mem_req         = 1'b1;
    sram_ready      = 1'b0;
    cnt_clr         = 1'b0;
    #1;
    rst = 1'b0;
    push(nm, C_NONE, 1'b0, 0, 0, 0);
  endtask

  // Monitor: one comparison per vector at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t       e;
        logic [4:0] got;
        e   = exp_q.pop_front();
        got = {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_all};
        n_vec++;
        if (got !== e.ctl || error !== e.err || stall_cnt !== e.sc ||
            flush_cnt !== e.fc || mem_wait_cnt !== e.mc) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b err=%b stall=%0d flush=%0d memw=%0d, want ctl=%b err=%b stall=%0d flush=%0d memw=%0d",
                   e.name, got, error, stall_cnt, flush_cnt, mem_wait_cnt,
                   e.ctl, e.err, e.sc, e.fc, e.mc);
        end else begin
          $display("vec %0d %s ok: ctl=%b err=%b stall=%0d flush=%0d memw=%0d",
                   n_vec, e.name, got, error, stall_cnt, flush_cnt, mem_wait_cnt);
        end
      end
    end
  end

  // Hard time limit.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, %0d vectors still queued", exp_q.size());
    $fatal(1, "time limit");
  end

  initial begin
    // Controls forced low while in reset regardless of inputs.
    vec("rst_haz",  0, 1, 0, 1, 0, 0, C_NONE, 0, 0, 0, 0);
    vec("rst_br",   0, 0, 1, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    vec("release",  1, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);

    // Two-cycle hazard.
    vec("haz1",     1, 1, 0, 0, 0, 0, C_HAZ,  0, 0, 0, 0);
    vec("haz2",     1, 1, 0, 0, 0, 0, C_HAZ,  0, 1, 0, 0);
    vec("haz_end",  1, 0, 0, 0, 0, 0, C_NONE, 0, 2, 0, 0);
    vec("clr1",     1, 0, 0, 0, 0, 1, C_NONE, 0, 2, 0, 0);

    // Hazard and branch together: branch wins.
    vec("haz_br",   1, 1, 1, 0, 0, 0, C_BR,   0, 0, 0, 0);
    vec("after_br", 1, 0, 0, 0, 0, 0, C_NONE, 0, 0, 1, 0);

    // SRAM wait for 5 cycles with a pending branch, then ready.
    for (int i = 0; i < 5; i++)
      vec("mw_br",  1, 0, 1, 1, 0, 0, C_MEM,  0, 0, 1, i);
    vec("ready_br", 1, 0, 1, 1, 1, 0, C_BR,   0, 0, 1, 5);
    vec("after_mw", 1, 0, 0, 0, 0, 0, C_NONE, 0, 0, 2, 5);

    // SRAM wait outranks a hazard; hazard takes over once the wait ends.
    vec("mw_haz",   1, 1, 0, 1, 0, 0, C_MEM,  0, 0, 2, 5);
    vec("haz_am",   1, 1, 0, 0, 0, 0, C_HAZ,  0, 0, 2, 6);
    vec("idle1",    1, 0, 0, 0, 0, 0, C_NONE, 0, 1, 2, 6);

    // Condition change restarts the watchdog run: 3 hazard, 1 wait, 3 hazard.
    for (int i = 0; i < 3; i++)
      vec("run_a",  1, 1, 0, 0, 0, 0, C_HAZ,  0, 1 + i, 2, 6);
    vec("run_mw",   1, 0, 0, 1, 0, 0, C_MEM,  0, 4, 2, 6);
    for (int i = 0; i < 3; i++)
      vec("run_b",  1, 1, 0, 0, 0, 0, C_HAZ,  0, 4 + i, 2, 7);
    vec("run_end",  1, 0, 0, 0, 0, 0, C_NONE, 0, 7, 2, 7);
    vec("clr2",     1, 0, 0, 0, 0, 1, C_NONE, 0, 7, 2, 7);

    // 20 hazard cycles in bursts of 2: stall_cnt saturates at 15.
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 2; j++)
        vec("sat_haz", 1, 1, 0, 0, 0, 0, C_HAZ, 0, sat(2 * k + j), 0, 0);
      vec("sat_gap",   1, 0, 0, 0, 0, 0, C_NONE, 0, sat(2 * k + 2), 0, 0);
    end
    vec("clr_haz",  1, 1, 0, 0, 0, 1, C_HAZ,  0, 15, 0, 0);
    vec("after_clr",1, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);

    // Continuous hazard: ERROR appears in cycle 5.
    for (int i = 0; i < 4; i++)
      vec("wd_haz", 1, 1, 0, 0, 0, 0, C_HAZ,  0, i, 0, 0);
    vec("wd_err",   1, 1, 0, 0, 0, 0, C_ERR,  1, 4, 0, 0);
    vec("err_idle", 1, 0, 0, 0, 0, 0, C_ERR,  1, 4, 0, 1);
    vec("err_br",   1, 0, 1, 0, 0, 0, C_ERR,  1, 4, 0, 2);
    vec("err_hold", 1, 0, 0, 0, 0, 0, C_ERR,  1, 4, 0, 3);
    vec("err_rst",  0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    vec("rst_hold", 0, 1, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);
    vec("release2", 1, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an SRAM wait.
    vec("mw_a",     1, 0, 0, 1, 0, 0, C_MEM,  0, 0, 0, 0);
    vec("mw_b",     1, 0, 0, 1, 0, 0, C_MEM,  0, 0, 0, 1);
    rst_mid("mw_rst");
    vec("rst_hold2",0, 0, 0, 1, 0, 0, C_NONE, 0, 0, 0, 0);
    vec("release3", 1, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);

    // SRAM timeout: 64 wait cycles are tolerated, ERROR in cycle 65.
    for (int i = 0; i < 64; i++)
      vec("mem_to", 1, 0, 0, 1, 0, 0, C_MEM,  0, 0, 0, sat(i));
    vec("mem_to_err", 1, 0, 0, 1, 0, 0, C_ERR, 1, 0, 0, 15);
    vec("to_hold",  1, 0, 0, 0, 0, 0, C_ERR,  1, 0, 0, 15);
    vec("final_rst",0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d vectors never checked, want 0", exp_q.size());
      n_bad++;
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
